// File: rtl/pcs_pkg.sv
// pcs_pkg: shared state encoding and default constants for the PCS TX scheduler
package pcs_pkg;
  typedef enum logic [1:0] {LINK_DOWN, IDLE, XFER, IPG} state_t;
  localparam int IPG_CYCLES_DEF = 12;
  localparam int LINK_UP_CYCLES_DEF = 16;
  localparam int CNT_W_DEF = 5;
endpackage

// File: rtl/pcs_rr_arbiter.sv
// pcs_rr_arbiter: two-request round-robin; pointer moves to the source that did not own the finished frame
module pcs_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic [1:0] cur,
  output logic [1:0] gnt
);
  logic ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (adv) ptr <= cur[0];
  assign gnt = &req ? (ptr ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/pcs_tx_scheduler.sv
// pcs_tx_scheduler: shares the PCS TX path between two frame sources with round-robin,
// inter-packet gap enforcement and link qualification from sync_status.
module pcs_tx_scheduler
  import pcs_pkg::*;
#(
  parameter int IPG_CYCLES     = IPG_CYCLES_DEF,
  parameter int LINK_UP_CYCLES = LINK_UP_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic       sync_status,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       TX_EN,
  output logic [7:0] TXD,
  output logic       xmit,
  output logic       link_up,
  output logic [1:0] grant,
  output logic       tx_abort
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic tx_en_n, xmit_n, link_n, abort_n, adv, sel_valid, sel_last, in_xfer;
  logic [7:0] txd_n, sel_data;
  logic [1:0] grant_n, gnt;

  assign in_xfer = state == XFER;
  assign req0_ready = in_xfer & grant[0];
  assign req1_ready = in_xfer & grant[1];
  assign sel_valid = |(grant & {req1_valid, req0_valid});
  assign sel_last = |(grant & {req1_last, req0_last});
  assign sel_data = grant[1] ? req1_data : req0_data;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;

  pcs_rr_arbiter u_arb (
    .clk(GTX_CLK),
    .rst_n(mr_main_reset),
    .req({req1_valid, req0_valid}),
    .adv(adv),
    .cur(grant),
    .gnt(gnt)
  );

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tx_en_n = 1'b0;
    txd_n = TXD;
    xmit_n = xmit;
    link_n = link_up;
    grant_n = grant;
    abort_n = 1'b0;
    adv = 1'b0;
    case (state)
      LINK_DOWN: begin
        cnt_n = sync_status ? cnt_inc : '0;
        if (sync_status && cnt == CNT_W'(LINK_UP_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n = '0;
          link_n = 1'b1;
          xmit_n = 1'b1;
        end
      end
      IDLE: if (|gnt) begin
        grant_n = gnt;
        state_n = XFER;
      end
      XFER: begin
        tx_en_n = sel_valid;
        txd_n = sel_valid ? sel_data : TXD;
        abort_n = !sel_valid;
        if (!sel_valid || sel_last) begin
          state_n = IPG;
          grant_n = '0;
          adv = 1'b1;
          cnt_n = '0;
        end
      end
      // the cycle still carrying the final byte (TX_EN=1) is not part of the gap
      IPG: if (!TX_EN) begin
        cnt_n = cnt_inc;
        if (cnt == CNT_W'(IPG_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n = '0;
        end
      end
      default: state_n = LINK_DOWN;
    endcase
    if (state != LINK_DOWN && !sync_status) begin
      state_n = LINK_DOWN;
      cnt_n = '0;
      tx_en_n = 1'b0;
      txd_n = TXD;
      xmit_n = 1'b0;
      link_n = 1'b0;
      grant_n = '0;
      abort_n = in_xfer && !(sel_valid && sel_last);
      adv = 1'b0;
    end
  end

  always_ff @(posedge GTX_CLK or negedge mr_main_reset)
    if (!mr_main_reset) begin
      state <= LINK_DOWN;
      cnt <= '0;
      TX_EN <= 1'b0;
      TXD <= '0;
      xmit <= 1'b0;
      link_up <= 1'b0;
      grant <= '0;
      tx_abort <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      TX_EN <= tx_en_n;
      TXD <= txd_n;
      xmit <= xmit_n;
      link_up <= link_n;
      grant <= grant_n;
      tx_abort <= abort_n;
    end
endmodule

// File: tb/tb_pcs_tx_scheduler.sv
// tb_pcs_tx_scheduler: directed scenarios plus randomized two-source traffic checked
// against a frame-level round-robin model of the transmitted byte stream.
module tb_pcs_tx_scheduler;
  localparam int IPG = 12;
  localparam int LUP = 16;

  logic GTX_CLK = 1'b0, mr_main_reset, sync_status;
  logic req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, TXD;
  logic TX_EN, xmit, link_up, tx_abort;
  logic [1:0] grant;

  int checks = 0, failures = 0;
  logic [8:0] q0[$], q1[$], fr0[$], fr1[$], e0[$], e1[$];
  logic [7:0] exp_q[$];
  logic en0 = 1'b1, en1 = 1'b1, mon_on = 1'b0, gap_chk = 1'b0, have_prev = 1'b0, prev_en = 1'b0;
  logic mptr;
  int gap = 0, n_abort = 0;

  pcs_tx_scheduler dut (
    .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset), .sync_status(sync_status),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .TX_EN(TX_EN), .TXD(TXD), .xmit(xmit), .link_up(link_up), .grant(grant), .tx_abort(tx_abort)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req0_valid = en0 && q0.size() != 0;
    req0_data = 8'h00;
    req0_last = 1'b0;
    if (q0.size() != 0) {req0_last, req0_data} = q0[0];
    req1_valid = en1 && q1.size() != 0;
    req1_data = 8'h00;
    req1_last = 1'b0;
    if (q1.size() != 0) {req1_last, req1_data} = q1[0];
  endtask

  // one clock: monitor at the falling edge, advance the sources just after the rising edge
  task automatic step();
    logic a0, a1;
    logic [7:0] e;
    @(negedge GTX_CLK);
    a0 = req0_valid & req0_ready;
    a1 = req1_valid & req1_ready;
    chk("rdy_nongrant", 32'({req1_ready & ~grant[1], req0_ready & ~grant[0]}), 0);
    if (tx_abort) n_abort++;
    if (TX_EN) begin
      if (!prev_en && gap_chk && have_prev) chk("gap", 32'(gap), IPG + 2);
      have_prev = 1'b1;
      gap = 0;
      if (mon_on) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'(TXD), 32'h100);
        else begin
          e = exp_q.pop_front();
          chk("txd", 32'(TXD), 32'(e));
        end
      end
    end else gap++;
    prev_en = TX_EN;
    @(posedge GTX_CLK);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    drive();
  endtask

  task automatic drain(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !TX_EN) break;
      step();
    end
    chk(tag, 32'(exp_q.size() + q0.size() + q1.size()), 0);
    repeat (IPG + 3) step();
  endtask

  task automatic relink(input string tag);
    sync_status = 1'b1;
    drive();
    repeat (LUP - 1) step();
    chk({tag, "_early"}, 32'({xmit, link_up}), 0);
    step();
    chk({tag, "_up"}, 32'({xmit, link_up}), 3);
  endtask

  task automatic push_frame(input int src, input logic [7:0] b[$]);
    foreach (b[i]) begin
      if (src == 0) q0.push_back({i == b.size() - 1, b[i]});
      else q1.push_back({i == b.size() - 1, b[i]});
    end
  endtask

  initial begin
    int n;
    logic [7:0] bytes[$];
    logic [8:0] x;
    logic pick;
    mr_main_reset = 1'b0;
    sync_status = 1'b0;
    drive();
    #2;
    chk("rst_outs", 32'({TX_EN, TXD, xmit, link_up, grant, tx_abort}), 0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 0);
    @(posedge GTX_CLK);
    #1;
    mr_main_reset = 1'b1;

    // link qualify: a run of 15 is not enough, a later run of 16 is
    sync_status = 1'b1;
    repeat (LUP - 1) step();
    chk("lq_first_run", 32'({xmit, link_up}), 0);
    sync_status = 1'b0;
    step();
    relink("lq_second");

    // single 4-byte frame from source 0
    mon_on = 1'b1;
    bytes = '{8'h55, 8'h55, 8'hD5, 8'hAA};
    push_frame(0, bytes);
    foreach (bytes[i]) exp_q.push_back(bytes[i]);
    drive();
    begin
      logic [7:0] en_pat;
      for (int i = 0; i < 8; i++) begin
        step();
        en_pat[i] = TX_EN;
        if (i < 4) chk("sf_grant", 32'(grant), 1);
        if (i == 4) chk("sf_grant_clr", 32'(grant), 0);
      end
      chk("sf_en_pat", 32'(en_pat), 32'h1E);
    end
    chk("sf_drain", 32'(exp_q.size()), 0);
    repeat (IPG) step();

    // underrun on source 1 after 2 of 5 bytes
    n_abort = 0;
    bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    push_frame(1, bytes);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    drive();
    for (int i = 0; i < 50 && q1.size() > 3; i++) step();
    chk("ur_progress", 32'(q1.size()), 3);
    en1 = 1'b0;
    drive();
    step();
    chk("ur_abort", 32'({tx_abort, TX_EN, grant}), 32'b1000);
    q1.delete();
    en1 = 1'b1;
    q1.push_back(9'h177);
    exp_q.push_back(8'h77);
    drive();
    n = 0;
    for (int i = 0; i < 40 && grant == 2'b00; i++) begin
      step();
      n++;
    end
    chk("ur_ipg_then_idle", 32'(n), IPG + 1);
    chk("ur_abort_once", 32'(n_abort), 1);
    chk("ur_single_grant", 32'(grant), 2);
    drain("ur_drain", 60);

    // contention: two frames each, served alternately starting with source 0
    gap_chk = 1'b1;
    have_prev = 1'b0;
    push_frame(0, '{8'hA0, 8'hA1});
    push_frame(0, '{8'hA2, 8'hA3});
    push_frame(1, '{8'hB0, 8'hB1});
    push_frame(1, '{8'hB2, 8'hB3});
    exp_q = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3};
    drive();
    drain("ct_drain", 300);
    gap_chk = 1'b0;

    // sync loss while byte 3 is being accepted
    n_abort = 0;
    push_frame(0, '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24});
    exp_q = '{8'h20, 8'h21};
    drive();
    for (int i = 0; i < 50 && q0.size() > 3; i++) step();
    chk("sl_progress", 32'(q0.size()), 3);
    sync_status = 1'b0;
    drive();
    step();
    chk("sl_outs", 32'({TX_EN, xmit, link_up, grant, tx_abort}), 1);
    q0.delete();
    drive();
    step();
    chk("sl_abort_pulse", 32'(tx_abort), 0);
    chk("sl_bytes", 32'(exp_q.size()), 0);
    relink("sl_relink");

    // last byte and sync loss together: completed frame, no abort
    push_frame(0, '{8'h30, 8'h31});
    exp_q = '{8'h30};
    drive();
    for (int i = 0; i < 50 && q0.size() > 1; i++) step();
    chk("sll_progress", 32'(q0.size()), 1);
    sync_status = 1'b0;
    drive();
    step();
    chk("sll_no_abort", 32'({tx_abort, TX_EN, link_up}), 0);
    q0.delete();
    drive();
    step();
    chk("sll_bytes", 32'(exp_q.size()), 0);
    relink("sll_relink");

    // asynchronous reset between clock edges during a frame
    push_frame(0, '{8'h40, 8'h41, 8'h42, 8'h43});
    exp_q = '{8'h40, 8'h41, 8'h42, 8'h43};
    drive();
    for (int i = 0; i < 20 && !TX_EN; i++) step();
    chk("ar_in_frame", 32'({TX_EN, grant}), 32'b101);
    #2;
    mr_main_reset = 1'b0;
    #1;
    chk("ar_outs", 32'({TX_EN, TXD, xmit, link_up, grant, tx_abort}), 0);
    chk("ar_ready", 32'({req1_ready, req0_ready}), 0);
    mr_main_reset = 1'b1;
    q0.delete();
    exp_q.delete();
    drive();

    // randomized rounds against a frame-level round-robin model
    mptr = 1'b0;
    relink("rnd_link");
    gap_chk = 1'b1;
    n_abort = 0;
    for (int r = 0; r < 6; r++) begin
      fr0.delete();
      fr1.delete();
      for (int s = 0; s < 2; s++) begin
        int nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          int len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) begin
            x = {b == len - 1, 8'($urandom)};
            if (s == 0) fr0.push_back(x);
            else fr1.push_back(x);
          end
        end
      end
      e0 = fr0;
      e1 = fr1;
      while (e0.size() != 0 || e1.size() != 0) begin
        pick = (e0.size() != 0 && e1.size() != 0) ? mptr : (e0.size() == 0);
        do begin
          x = pick ? e1.pop_front() : e0.pop_front();
          exp_q.push_back(x[7:0]);
        end while (!x[8]);
        mptr = !pick;
      end
      q0 = fr0;
      q1 = fr1;
      have_prev = 1'b0;
      drive();
      drain("rnd_drain", 1500);
    end
    chk("rnd_no_abort", 32'(n_abort), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
